// File: rtl/dist_ram_loader_m.sv
// rtl/dist_ram_loader_m.sv - distributed RAM filled by a valid/ready word stream, registered random-access read
module dist_ram_loader_m #(
   parameter int ADDR_WIDTH = 5,
   parameter int WORD_WIDTH = 16,
   parameter int RAM_SIZE   = 2**ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  abort,
   input  logic [WORD_WIDTH-1:0] wr_data,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   output logic [ADDR_WIDTH:0]   fill_cnt,
   output logic                  busy,
   output logic                  loaded,
   output logic                  load_done,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [WORD_WIDTH-1:0] rd_data
);

   typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

   // Index of the final table word; a transfer here completes the load.
   localparam logic [ADDR_WIDTH:0] LAST_IDX = (ADDR_WIDTH+1)'(RAM_SIZE - 1);
   localparam logic [ADDR_WIDTH:0] CNT_ONE  = (ADDR_WIDTH+1)'(1);

   state_t state, state_nxt;
   logic   xfer;
   logic   last_xfer;

   (* ram_style = "distributed" *) logic [WORD_WIDTH-1:0] ram [RAM_SIZE];

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next state and handshake; start outranks abort, and both block a transfer.
   always_comb begin
      state_nxt = state;
      wr_ready  = 1'b0;
      busy      = 1'b0;
      loaded    = 1'b0;
      xfer      = 1'b0;
      last_xfer = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = LOAD;
         end
         LOAD: begin
            busy      = 1'b1;
            wr_ready  = !start && !abort;
            xfer      = wr_valid && wr_ready;
            last_xfer = xfer && (fill_cnt == LAST_IDX);
            if (start)          state_nxt = LOAD;
            else if (abort)     state_nxt = IDLE;
            else if (last_xfer) state_nxt = DONE;
         end
         DONE: begin
            loaded = 1'b1;
            if (start) state_nxt = LOAD;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Write index and completion pulse; the index survives an abort so partial progress stays visible.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fill_cnt  <= '0;
         load_done <= 1'b0;
      end else begin
         load_done <= last_xfer;
         if (start)     fill_cnt <= '0;
         else if (xfer) fill_cnt <= fill_cnt + CNT_ONE;
      end
   end

   // Table storage; never reset so a reset does not wipe a downloaded table.
   always_ff @(posedge clk) begin
      if (xfer) ram[fill_cnt[ADDR_WIDTH-1:0]] <= wr_data;
   end

   // Registered read; a same-address write in this cycle is seen on the next read.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rd_data <= '0;
      else        rd_data <= ram[rd_addr];
   end

endmodule

// File: tb/tb_dist_ram_loader_m.sv
// tb/tb_dist_ram_loader_m.sv - directed self-checking bench for dist_ram_loader_m
module tb_dist_ram_loader_m;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   // Instance A: default 32-word table.
   logic        start = 1'b0, abort = 1'b0, wr_valid = 1'b0;
   logic [15:0] wr_data = '0;
   logic [4:0]  rd_addr = '0;
   logic        wr_ready, busy, loaded, load_done;
   logic [5:0]  fill_cnt;
   logic [15:0] rd_data;

   // Instance B: 20-word table in a 5-bit address space.
   logic        b_start = 1'b0, b_abort = 1'b0, b_wr_valid = 1'b0;
   logic [15:0] b_wr_data = '0;
   logic [4:0]  b_rd_addr = '0;
   logic        b_wr_ready, b_busy, b_loaded, b_load_done;
   logic [5:0]  b_fill_cnt;
   logic [15:0] b_rd_data;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   dist_ram_loader_m #(.ADDR_WIDTH(5), .WORD_WIDTH(16), .RAM_SIZE(32)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .fill_cnt(fill_cnt), .busy(busy), .loaded(loaded), .load_done(load_done),
      .rd_addr(rd_addr), .rd_data(rd_data)
   );

   dist_ram_loader_m #(.ADDR_WIDTH(5), .WORD_WIDTH(16), .RAM_SIZE(20)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(b_start), .abort(b_abort),
      .wr_data(b_wr_data), .wr_valid(b_wr_valid), .wr_ready(b_wr_ready),
      .fill_cnt(b_fill_cnt), .busy(b_busy), .loaded(b_loaded), .load_done(b_load_done),
      .rd_addr(b_rd_addr), .rd_data(b_rd_data)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      checks++;
      if ({wr_ready, busy, loaded, load_done} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_flags got=%b exp=0000", {wr_ready, busy, loaded, load_done});
      end
      checks++;
      if (fill_cnt !== 6'd0) begin
         failures++;
         $display("FAIL reset_fill_cnt got=%0d exp=0", fill_cnt);
      end
      checks++;
      if (rd_data !== 16'h0000) begin
         failures++;
         $display("FAIL reset_rd_data got=%h exp=0000", rd_data);
      end
      rst_n = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic test_basic_load();
      int ready_cycles = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 32; i++) begin
         wr_valid = 1'b1;
         wr_data  = 16'h1000 + 16'(i);
         #1;
         if (wr_ready === 1'b1) ready_cycles++;
         checks++;
         if (load_done !== 1'b0) begin
            failures++;
            $display("FAIL basic_early_done word=%0d got=%b exp=0", i, load_done);
         end
         tick();
      end
      wr_valid = 1'b0;
      checks++;
      if (ready_cycles != 32) begin
         failures++;
         $display("FAIL basic_ready_cycles got=%0d exp=32", ready_cycles);
      end
      checks++;
      if ({load_done, loaded, busy, wr_ready} !== 4'b1100) begin
         failures++;
         $display("FAIL basic_done_flags got=%b exp=1100", {load_done, loaded, busy, wr_ready});
      end
      checks++;
      if (fill_cnt !== 6'd32) begin
         failures++;
         $display("FAIL basic_fill_cnt got=%0d exp=32", fill_cnt);
      end
      // abort in DONE must be ignored
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checks++;
      if ({load_done, loaded} !== 2'b01) begin
         failures++;
         $display("FAIL basic_pulse_or_abort_done got=%b exp=01", {load_done, loaded});
      end
      for (int i = 0; i < 32; i++) begin
         rd_addr = 5'(i);
         tick();
         checks++;
         if (rd_data !== 16'h1000 + 16'(i)) begin
            failures++;
            $display("FAIL basic_read addr=%0d got=%h exp=%h", i, rd_data, 16'h1000 + 16'(i));
         end
      end
   endtask

   task automatic test_backpressure();
      int k = 0;
      int cyc = 0;
      int done_cnt = 0;
      logic pat;
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if ({loaded, busy, fill_cnt} !== {2'b01, 6'd0}) begin
         failures++;
         $display("FAIL bp_restart got loaded=%b busy=%b fill=%0d exp 0 1 0", loaded, busy, fill_cnt);
      end
      while (k < 32 && cyc < 200) begin
         pat = (cyc % 4 == 0) || (cyc % 4 == 3);
         wr_valid = pat;
         wr_data  = 16'h1000 + 16'(k);
         tick();
         if (pat) k++;
         cyc++;
         if (load_done === 1'b1) done_cnt++;
         checks++;
         if (fill_cnt !== 6'(k)) begin
            failures++;
            $display("FAIL bp_fill_cnt cycle=%0d got=%0d exp=%0d", cyc, fill_cnt, k);
         end
      end
      wr_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (load_done === 1'b1) done_cnt++;
      end
      checks++;
      if (done_cnt != 1) begin
         failures++;
         $display("FAIL bp_done_count got=%0d exp=1", done_cnt);
      end
      for (int i = 0; i < 32; i++) begin
         rd_addr = 5'(i);
         tick();
         checks++;
         if (rd_data !== 16'h1000 + 16'(i)) begin
            failures++;
            $display("FAIL bp_read addr=%0d got=%h exp=%h", i, rd_data, 16'h1000 + 16'(i));
         end
      end
   endtask

   task automatic test_abort();
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 10; i++) begin
         wr_valid = 1'b1;
         wr_data  = 16'h2000 + 16'(i);
         tick();
      end
      abort    = 1'b1;
      wr_data  = 16'h2BAD;
      #1;
      checks++;
      if (wr_ready !== 1'b0) begin
         failures++;
         $display("FAIL abort_ready got=%b exp=0", wr_ready);
      end
      tick();
      abort    = 1'b0;
      wr_valid = 1'b0;
      checks++;
      if ({busy, loaded, wr_ready, fill_cnt} !== {3'b000, 6'd10}) begin
         failures++;
         $display("FAIL abort_state got busy=%b loaded=%b ready=%b fill=%0d exp 0 0 0 10",
                  busy, loaded, wr_ready, fill_cnt);
      end
      for (int i = 0; i <= 10; i++) begin
         rd_addr = 5'(i);
         tick();
         checks++;
         if (rd_data !== ((i < 10) ? 16'h2000 + 16'(i) : 16'h100A)) begin
            failures++;
            $display("FAIL abort_read addr=%0d got=%h exp=%h", i, rd_data,
                     (i < 10) ? 16'h2000 + 16'(i) : 16'h100A);
         end
      end
   endtask

   task automatic test_restart();
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 7; i++) begin
         wr_valid = 1'b1;
         wr_data  = 16'h3000 + 16'(i);
         tick();
      end
      start   = 1'b1;
      wr_data = 16'h3BAD;
      #1;
      checks++;
      if (wr_ready !== 1'b0 || fill_cnt !== 6'd7) begin
         failures++;
         $display("FAIL restart_pre got ready=%b fill=%0d exp 0 7", wr_ready, fill_cnt);
      end
      tick();
      start = 1'b0;
      checks++;
      if ({busy, fill_cnt} !== {1'b1, 6'd0}) begin
         failures++;
         $display("FAIL restart_post got busy=%b fill=%0d exp 1 0", busy, fill_cnt);
      end
      for (int i = 0; i < 32; i++) begin
         wr_data = 16'hAA00 + 16'(i);
         tick();
      end
      wr_valid = 1'b0;
      checks++;
      if ({loaded, fill_cnt} !== {1'b1, 6'd32}) begin
         failures++;
         $display("FAIL restart_loaded got loaded=%b fill=%0d exp 1 32", loaded, fill_cnt);
      end
      for (int i = 0; i < 32; i++) begin
         rd_addr = 5'(i);
         tick();
         checks++;
         if (rd_data !== 16'hAA00 + 16'(i)) begin
            failures++;
            $display("FAIL restart_read addr=%0d got=%h exp=%h", i, rd_data, 16'hAA00 + 16'(i));
         end
      end
   endtask

   task automatic test_read_during_write();
      rd_addr = 5'd5;
      start   = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 32; i++) begin
         wr_valid = 1'b1;
         wr_data  = 16'h5500 + 16'(i);
         tick();
         if (i == 5) begin
            checks++;
            if (rd_data !== 16'hAA05) begin
               failures++;
               $display("FAIL rdw_old got=%h exp=aa05", rd_data);
            end
         end
         if (i == 6) begin
            checks++;
            if (rd_data !== 16'h5505) begin
               failures++;
               $display("FAIL rdw_new got=%h exp=5505", rd_data);
            end
         end
      end
      wr_valid = 1'b0;
      tick();
   endtask

   task automatic test_reset_midload();
      b_start = 1'b1;
      tick();
      b_start = 1'b0;
      for (int i = 0; i < 12; i++) begin
         b_wr_valid = 1'b1;
         b_wr_data  = 16'h4000 + 16'(i);
         tick();
      end
      checks++;
      if ({b_busy, b_fill_cnt} !== {1'b1, 6'd12}) begin
         failures++;
         $display("FAIL midrst_pre got busy=%b fill=%0d exp 1 12", b_busy, b_fill_cnt);
      end
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({b_wr_ready, b_busy, b_loaded, b_load_done, b_fill_cnt, b_rd_data} !== 26'd0) begin
         failures++;
         $display("FAIL midrst_async got ready=%b busy=%b loaded=%b done=%b fill=%0d rd=%h exp all 0",
                  b_wr_ready, b_busy, b_loaded, b_load_done, b_fill_cnt, b_rd_data);
      end
      b_wr_valid = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      b_wr_valid = 1'b1;
      #1;
      checks++;
      if ({b_wr_ready, b_busy} !== 2'b00) begin
         failures++;
         $display("FAIL midrst_needs_start got ready=%b busy=%b exp 0 0", b_wr_ready, b_busy);
      end
      b_start = 1'b1;
      tick();
      b_start = 1'b0;
      for (int i = 0; i < 20; i++) begin
         b_wr_data = 16'h6000 + 16'(i);
         tick();
         if (i == 18) begin
            checks++;
            if ({b_load_done, b_fill_cnt} !== {1'b0, 6'd19}) begin
               failures++;
               $display("FAIL midrst_w18 got done=%b fill=%0d exp 0 19", b_load_done, b_fill_cnt);
            end
         end
      end
      b_wr_valid = 1'b0;
      checks++;
      if ({b_load_done, b_loaded, b_wr_ready, b_fill_cnt} !== {3'b110, 6'd20}) begin
         failures++;
         $display("FAIL midrst_done got done=%b loaded=%b ready=%b fill=%0d exp 1 1 0 20",
                  b_load_done, b_loaded, b_wr_ready, b_fill_cnt);
      end
      b_rd_addr = 5'd0;
      tick();
      checks++;
      if (b_rd_data !== 16'h6000) begin
         failures++;
         $display("FAIL midrst_read0 got=%h exp=6000", b_rd_data);
      end
      b_rd_addr = 5'd19;
      tick();
      checks++;
      if (b_rd_data !== 16'h6013) begin
         failures++;
         $display("FAIL midrst_read19 got=%h exp=6013", b_rd_data);
      end
   endtask

   initial begin
      test_reset();
      test_basic_load();
      test_backpressure();
      test_abort();
      test_restart();
      test_read_during_write();
      test_reset_midload();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dist_ram_loader_m.md
Name: dist_ram_loader_m

Overview:
Distributed-memory RAM that is filled sequentially through a valid/ready write stream and read back through a registered random-access read port. It is the writer-side counterpart of the distributed ROM modules. Lookup tables can be downloaded at run time instead of being fixed at elaboration. It sits between a configuration/DMA source, which streams words, and datapath logic, which reads the table.

Parameters:
ADDR_WIDTH, 5, read/write address width
WORD_WIDTH, 16, data word width
RAM_SIZE, 2**ADDR_WIDTH, number of words; 2 <= RAM_SIZE <= 2**ADDR_WIDTH; need not be a power of two

Ports:
clk  input  1  clock; all logic on posedge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request to begin (or restart) a table load at word 0
abort  input  1  one-cycle request to stop the current load
wr_data  input  WORD_WIDTH  stream word
wr_valid  input  1  wr_data valid
wr_ready  output  1  block accepts a word this cycle
fill_cnt  output  ADDR_WIDTH+1  words written in the current or last load
busy  output  1  load in progress
loaded  output  1  table completely loaded
load_done  output  1  one-cycle pulse when the last word is written
rd_addr  input  ADDR_WIDTH  read address
rd_data  output  WORD_WIDTH  registered read data

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Storage: array of RAM_SIZE words with attribute ram_style="distributed". Contents are not reset and are undefined until written.
- Reset values: state=IDLE, wr_ready=0, busy=0, loaded=0, load_done=0, fill_cnt=0, rd_data=0.
- FSM states are IDLE, LOAD and DONE.
  - IDLE: start -> LOAD. fill_cnt <= 0.
  - LOAD: wr_ready=1 combinationally, busy=1.
  - Transfer occurs when wr_valid & wr_ready. On a transfer: ram[fill_cnt] <= wr_data, fill_cnt <= fill_cnt+1.
  - A transfer with fill_cnt==RAM_SIZE-1 -> DONE. In that case loaded <= 1 and load_done=1 for exactly the next cycle.
  - abort in LOAD (priority over a same-cycle transfer, which is not accepted) -> IDLE. fill_cnt keeps its value, loaded stays 0, and the partial contents remain.
  - start in LOAD: restart at word 0, and any same-cycle transfer is dropped (wr_ready=0 that cycle). start has priority over abort.
  - DONE: loaded=1, wr_ready=0. start -> LOAD, with loaded <= 0 and fill_cnt <= 0.
  - abort in IDLE or DONE has no effect.
- wr_ready is 0 in IDLE and DONE. It is also 0 in any cycle where start or abort is asserted.
- Write index: fill_cnt never exceeds RAM_SIZE. Writes never wrap. RAM_SIZE words is the complete table.
- Read port: rd_data <= ram[rd_addr] every cycle (1-cycle latency), independent of state.
  - Read-during-write to the same address returns the old word; the new word is visible on the following read.
  - rd_addr >= RAM_SIZE returns an undefined value. A bench must not check this case.
- Reset asserted mid-load forces the reset values immediately (asynchronously). RAM contents are untouched. After reset release, a new start is required.
- load_done never coincides with wr_ready=1.
- Implementation target: 120-400 lines of RTL.

Test Plan:
1. Basic load: rst_n released, start, then 32 words 0x1000+i with wr_valid held high -> wr_ready high 32 cycles, load_done pulses in the cycle after word 31, loaded=1, fill_cnt=32. Reading rd_addr=0..31 gives 0x1000+i one cycle later.
2. Back-pressure from the source: wr_valid toggles 1,0,0,1 during the load -> only valid cycles advance fill_cnt. Final contents are identical to scenario 1 and load_done occurs exactly once.
3. Abort after 10 words -> IDLE, busy=0, loaded=0, fill_cnt=10, ram[0..9] written. A transfer offered in the abort cycle is not written (ram[10] keeps its old value).
4. Restart: start while fill_cnt=7 -> fill_cnt=0. The next stream of words 0xAAAA.. overwrites from address 0, and the word offered in the start cycle is ignored.
5. Read-during-write: reload with rd_addr=5 held. In the cycle after word 5 is written, rd_data = old value; the following cycle, rd_data = new value.
6. Reset mid-load (RAM_SIZE=20, ADDR_WIDTH=5) at fill_cnt=12 -> outputs immediately at reset values. After release and a new start plus 20 words, load_done occurs after word 19 and fill_cnt=20.
